// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_arb_pkg;
    localparam int          ARB_DATA_W      = 32;
    localparam int          ARB_ADDR_W      = 32;
    localparam int unsigned ARB_DEPTH_WORDS = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } arb_state_e;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // Word-aligned and inside the memory array.
    function automatic logic addr_ok(input logic [ARB_ADDR_W-1:0] addr,
                                     input int unsigned depth_words);
        return (addr[1:0] == 2'b00) && ((addr >> 2) < depth_words);
    endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester A/B handshakes plus the data-memory port, as seen by the arbiter.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W,
    parameter int ADDR_W = ARB_ADDR_W
);
    logic              ReqA_40, WrA_40, AckA_40, ErrA_40;
    logic [ADDR_W-1:0] AddrA_40;
    logic [DATA_W-1:0] WDataA_40, RDataA_40;
    logic              ReqB_40, WrB_40, AckB_40, ErrB_40;
    logic [ADDR_W-1:0] AddrB_40;
    logic [DATA_W-1:0] WDataB_40, RDataB_40;
    logic [ADDR_W-1:0] MemAddress_40;
    logic [DATA_W-1:0] MemWriteData_40, MemReadData_40;
    logic              MemRead_40, MemWrite_40, Busy_40;

    modport slave (
        input  ReqA_40, WrA_40, AddrA_40, WDataA_40,
        input  ReqB_40, WrB_40, AddrB_40, WDataB_40, MemReadData_40,
        output AckA_40, ErrA_40, RDataA_40, AckB_40, ErrB_40, RDataB_40,
        output MemAddress_40, MemWriteData_40, MemRead_40, MemWrite_40, Busy_40
    );
    modport master (
        output ReqA_40, WrA_40, AddrA_40, WDataA_40,
        output ReqB_40, WrB_40, AddrB_40, WDataB_40, MemReadData_40,
        input  AckA_40, ErrA_40, RDataA_40, AckB_40, ErrB_40, RDataB_40,
        input  MemAddress_40, MemWriteData_40, MemRead_40, MemWrite_40, Busy_40
    );
endinterface

// File: rtl/dmem_arbiter_rr.sv
// Two-input round-robin grant; the pointer moves to the losing side on every grant.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic       Clk_40,
    input  logic       Reset_40,
    input  logic       en,
    input  logic [1:0] req,
    output logic       gnt_vld,
    output logic       gnt_id
);
    logic ptr_q;

    always_comb begin
        gnt_vld = |req;
        gnt_id  = (req == 2'b11) ? ptr_q : req[1];
    end

    always_ff @(posedge Clk_40 or posedge Reset_40) begin
        if (Reset_40)
            ptr_q <= REQ_A;
        else if (en && gnt_vld)
            ptr_q <= ~gnt_id;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between CPU (A) and loader (B): IDLE -> ACCESS -> DONE.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int          DATA_W      = ARB_DATA_W,
    parameter int          ADDR_W      = ARB_ADDR_W,
    parameter int unsigned DEPTH_WORDS = ARB_DEPTH_WORDS
)(
    input  logic           Clk_40,
    input  logic           Reset_40,
    dmem_arbiter_if.slave  bus
);
    arb_state_e        state_q, state_d;
    logic              gnt_vld, gnt_id;
    logic              cmd_id, cmd_wr, cmd_err;
    logic [ADDR_W-1:0] mem_addr_q, win_addr;
    logic [DATA_W-1:0] mem_wdata_q, win_wdata, rdata_a_q, rdata_b_q;
    logic              win_wr, win_ok, grant;

    rr_arbiter2 u_rr (
        .Clk_40   (Clk_40),
        .Reset_40 (Reset_40),
        .en       (state_q == IDLE),
        .req      ({bus.ReqB_40, bus.ReqA_40}),
        .gnt_vld  (gnt_vld),
        .gnt_id   (gnt_id)
    );

    always_comb begin
        win_wr    = (gnt_id == REQ_B) ? bus.WrB_40    : bus.WrA_40;
        win_addr  = (gnt_id == REQ_B) ? bus.AddrB_40  : bus.AddrA_40;
        win_wdata = (gnt_id == REQ_B) ? bus.WDataB_40 : bus.WDataA_40;
        win_ok    = addr_ok(win_addr, DEPTH_WORDS);
        grant     = (state_q == IDLE) && gnt_vld;
    end

    always_ff @(posedge Clk_40 or posedge Reset_40) begin
        if (Reset_40) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Memory controls come only from registers so they cannot glitch on requester inputs.
    always_comb begin
        state_d             = state_q;
        bus.MemRead_40      = 1'b0;
        bus.MemWrite_40     = 1'b0;
        bus.MemAddress_40   = mem_addr_q;
        bus.MemWriteData_40 = mem_wdata_q;
        bus.Busy_40         = (state_q != IDLE);
        bus.AckA_40         = 1'b0;
        bus.AckB_40         = 1'b0;
        bus.ErrA_40         = 1'b0;
        bus.ErrB_40         = 1'b0;
        bus.RDataA_40       = rdata_a_q;
        bus.RDataB_40       = rdata_b_q;
        unique case (state_q)
            IDLE:    if (gnt_vld) state_d = win_ok ? ACCESS : DONE;
            ACCESS: begin
                state_d         = DONE;
                bus.MemWrite_40 = cmd_wr;
                bus.MemRead_40  = ~cmd_wr;
            end
            DONE: begin
                state_d     = IDLE;
                bus.AckA_40 = (cmd_id == REQ_A);
                bus.AckB_40 = (cmd_id == REQ_B);
                bus.ErrA_40 = (cmd_id == REQ_A) && cmd_err;
                bus.ErrB_40 = (cmd_id == REQ_B) && cmd_err;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk_40 or posedge Reset_40) begin
        if (Reset_40) begin
            cmd_id      <= REQ_A;
            cmd_wr      <= 1'b0;
            cmd_err     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
        end else begin
            if (grant) begin
                cmd_id  <= gnt_id;
                cmd_wr  <= win_wr;
                cmd_err <= ~win_ok;
                // Rejected commands never reach the memory pins.
                if (win_ok) begin
                    mem_addr_q  <= win_addr;
                    mem_wdata_q <= win_wdata;
                end
            end
            if (state_q == ACCESS && !cmd_wr) begin
                if (cmd_id == REQ_B) rdata_b_q <= bus.MemReadData_40;
                else                 rdata_a_q <= bus.MemReadData_40;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a transaction-level model of the two ports.
module tb_dmem_arbiter;
    logic Clk_40 = 1'b0;
    logic Reset_40 = 1'b1;
    always #5 Clk_40 = ~Clk_40;

    dmem_arbiter_if bus ();
    dmem_arbiter u_dut (.Clk_40(Clk_40), .Reset_40(Reset_40), .bus(bus));

    // Data memory: preload pattern overlaid with words written so far.
    logic [31:0] wmem [64];
    bit          wvalid [64];
    function automatic logic [31:0] preload(input int i);
        return 32'hA500_0000 + 32'(i) * 32'h0001_0203;
    endfunction
    always @(posedge Clk_40)
        if (bus.MemWrite_40) begin
            wmem[bus.MemAddress_40[7:2]]   <= bus.MemWriteData_40;
            wvalid[bus.MemAddress_40[7:2]] <= 1'b1;
        end
    assign bus.MemReadData_40 = wvalid[bus.MemAddress_40[7:2]] ? wmem[bus.MemAddress_40[7:2]]
                                                               : preload(int'(bus.MemAddress_40[7:2]));

    // Reference model state
    logic [31:0] ref_mem [64];
    logic [31:0] ref_rd [2];
    bit          ref_ptr;
    int          total = 0, passed = 0;

    function automatic bit ok(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < 64);
    endfunction

    function automatic logic [31:0] rand_addr();
        int r = $urandom_range(7);
        if (r == 0) return 32'($urandom_range(63)) * 4 + 32'($urandom_range(3, 1));
        if (r == 1) return 32'($urandom_range(79, 64)) * 4;
        return 32'($urandom_range(63)) * 4;
    endfunction

    task automatic drive(input int p, input bit rq, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin bus.ReqA_40 = rq; bus.WrA_40 = wr; bus.AddrA_40 = a; bus.WDataA_40 = d; end
        else        begin bus.ReqB_40 = rq; bus.WrB_40 = wr; bus.AddrB_40 = a; bus.WDataB_40 = d; end
    endtask

    // One or two commands issued together from IDLE; every cycle is checked against the schedule.
    task automatic do_txn(input bit va, input bit wa, input logic [31:0] aa, input logic [31:0] da,
                          input bit vb, input bit wb, input logic [31:0] ab, input logic [31:0] db);
        bit v[2], w[2], er[2];
        logic [31:0] ad[2], wd[2], nrd[2];
        int s[2], ak[2], first, last;
        bit e_mw, e_mr, e_acc;
        logic [31:0] e_addr, e_wd;
        v = '{va, vb}; w = '{wa, wb}; ad = '{aa, ab}; wd = '{da, db};
        if (!va && !vb) return;
        for (int p = 0; p < 2; p++) begin er[p] = !ok(ad[p]); s[p] = -10; ak[p] = -10; nrd[p] = ref_rd[p]; end
        first = (va && vb) ? int'(ref_ptr) : (va ? 0 : 1);
        s[first] = 0; ak[first] = er[first] ? 1 : 2; last = first;
        ref_ptr = (first == 0);
        if (va && vb) begin
            last = 1 - first;
            s[last] = ak[first] + 1; ak[last] = s[last] + (er[last] ? 1 : 2);
            ref_ptr = (last == 0);
        end
        for (int k = 0; k < 2; k++) begin
            int p = (k == 0) ? first : 1 - first;
            if (!v[p] || er[p]) continue;
            if (w[p]) ref_mem[ad[p] / 4] = wd[p];
            else      nrd[p] = ref_mem[ad[p] / 4];
        end
        @(negedge Clk_40);
        drive(0, va, wa, aa, da);
        drive(1, vb, wb, ab, db);
        for (int c = 0; c <= ak[last]; c++) begin
            if (c > 0) @(negedge Clk_40);
            e_mw = 0; e_mr = 0; e_acc = 0; e_addr = '0; e_wd = '0;
            for (int p = 0; p < 2; p++)
                if (v[p] && !er[p] && c == s[p] + 1) begin
                    e_acc = 1; e_mw = w[p]; e_mr = !w[p]; e_addr = ad[p]; e_wd = wd[p];
                end
            for (int p = 0; p < 2; p++) begin
                logic ack_o, err_o; logic [31:0] rd_o, rd_e;
                ack_o = p ? bus.AckB_40 : bus.AckA_40;
                err_o = p ? bus.ErrB_40 : bus.ErrA_40;
                rd_o  = p ? bus.RDataB_40 : bus.RDataA_40;
                rd_e  = (v[p] && c >= ak[p]) ? nrd[p] : ref_rd[p];
                total++; if (ack_o !== (v[p] && c == ak[p]))
                    $display("FAIL ack port%0d cycle%0d: got %b exp %b", p, c, ack_o, v[p] && c == ak[p]);
                else passed++;
                total++; if (err_o !== (v[p] && c == ak[p] && er[p]))
                    $display("FAIL err port%0d cycle%0d: got %b exp %b", p, c, err_o, v[p] && c == ak[p] && er[p]);
                else passed++;
                total++; if (rd_o !== rd_e)
                    $display("FAIL rdata port%0d cycle%0d: got %h exp %h", p, c, rd_o, rd_e);
                else passed++;
                if (v[p] && c == ak[p]) drive(p, 0, 0, '0, '0);
            end
            total++; if ({bus.MemWrite_40, bus.MemRead_40} !== {e_mw, e_mr})
                $display("FAIL memctl cycle%0d: got wr%b rd%b exp wr%b rd%b", c, bus.MemWrite_40, bus.MemRead_40, e_mw, e_mr);
            else passed++;
            total++; if (bus.Busy_40 !== ((v[0] && c > s[0] && c <= ak[0]) || (v[1] && c > s[1] && c <= ak[1])))
                $display("FAIL busy cycle%0d: got %b", c, bus.Busy_40);
            else passed++;
            if (e_acc) begin
                total++; if (bus.MemAddress_40 !== e_addr || (e_mw && bus.MemWriteData_40 !== e_wd))
                    $display("FAIL membus cycle%0d: got %h/%h exp %h/%h", c, bus.MemAddress_40, bus.MemWriteData_40, e_addr, e_wd);
                else passed++;
            end
        end
        ref_rd = nrd;
    endtask

    task automatic test_reset();
        #2;
        total++; if ({bus.AckA_40, bus.AckB_40, bus.ErrA_40, bus.ErrB_40, bus.MemRead_40, bus.MemWrite_40, bus.Busy_40} !== 7'b0)
            $display("FAIL reset_ctl: got %b exp 0", {bus.AckA_40, bus.AckB_40, bus.ErrA_40, bus.ErrB_40, bus.MemRead_40, bus.MemWrite_40, bus.Busy_40});
        else passed++;
        total++; if ({bus.RDataA_40, bus.RDataB_40, bus.MemAddress_40, bus.MemWriteData_40} !== 128'b0)
            $display("FAIL reset_data: got %h exp 0", {bus.RDataA_40, bus.RDataB_40, bus.MemAddress_40, bus.MemWriteData_40});
        else passed++;
        @(negedge Clk_40) Reset_40 = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] w4;
        @(negedge Clk_40) drive(0, 1, 1, 32'h10, 32'hDEADBEEF);
        @(negedge Clk_40);
        total++; if (bus.MemWrite_40 !== 1'b1 || bus.MemAddress_40 !== 32'h10)
            $display("FAIL midwr_access: got wr%b addr %h exp wr1 addr 10", bus.MemWrite_40, bus.MemAddress_40);
        else passed++;
        #1 Reset_40 = 1'b1;
        #1;
        total++; if ({bus.MemWrite_40, bus.MemRead_40, bus.Busy_40, bus.AckA_40, bus.AckB_40} !== 5'b0)
            $display("FAIL midwr_ctl: got %b exp 0", {bus.MemWrite_40, bus.MemRead_40, bus.Busy_40, bus.AckA_40, bus.AckB_40});
        else passed++;
        total++; if ({bus.RDataA_40, bus.RDataB_40, bus.MemAddress_40, bus.MemWriteData_40} !== 128'b0)
            $display("FAIL midwr_data: got %h exp 0", {bus.RDataA_40, bus.RDataB_40, bus.MemAddress_40, bus.MemWriteData_40});
        else passed++;
        drive(0, 0, 0, '0, '0);
        @(negedge Clk_40) Reset_40 = 1'b0;
        ref_ptr = 0; ref_rd = '{32'h0, 32'h0};
        w4 = wvalid[4] ? wmem[4] : preload(4);
        total++; if (w4 !== ref_mem[4])
            $display("FAIL midwr_word4: got %h exp %h", w4, ref_mem[4]);
        else passed++;
    endtask

    task automatic test_simultaneous();
        do_txn(1, 0, 32'h00, 32'h0, 1, 1, 32'h04, 32'hCAFEF00D);
        do_txn(1, 0, 32'h04, 32'h0, 0, 0, 32'h0, 32'h0);
        total++; if (bus.RDataA_40 !== 32'hCAFEF00D)
            $display("FAIL simul_readback: got %h exp cafef00d", bus.RDataA_40);
        else passed++;
    endtask

    task automatic test_single_a();
        do_txn(1, 1, 32'h08, 32'h12345678, 0, 0, 32'h0, 32'h0);
        do_txn(1, 0, 32'h08, 32'h0, 0, 0, 32'h0, 32'h0);
        total++; if (bus.RDataA_40 !== 32'h12345678)
            $display("FAIL single_readback: got %h exp 12345678", bus.RDataA_40);
        else passed++;
    endtask

    task automatic test_errors();
        do_txn(0, 0, 32'h0, 32'h0, 1, 1, 32'h06, 32'h55AA55AA);
        do_txn(1, 0, 32'h100, 32'h0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic test_round_robin();
        int cnt[2], exp_id, last_c, nack;
        bit w[2]; logic [31:0] ad[2], wd[2];
        cnt = '{0, 0}; exp_id = int'(ref_ptr); last_c = -1; nack = 0;
        @(negedge Clk_40);
        for (int p = 0; p < 2; p++) begin
            w[p] = 1'($urandom); ad[p] = 32'($urandom_range(63)) * 4; wd[p] = $urandom;
            drive(p, 1, w[p], ad[p], wd[p]);
        end
        for (int c = 0; c < 40 && nack < 6; c++) begin
            if (c > 0) @(negedge Clk_40);
            total++; if (bus.AckA_40 && bus.AckB_40) $display("FAIL rr_both_ack cycle%0d: got 11 exp not both", c);
            else passed++;
            for (int p = 0; p < 2; p++) begin
                if (!(p ? bus.AckB_40 : bus.AckA_40)) continue;
                total++; if (p != exp_id) $display("FAIL rr_order ack%0d: got port%0d exp port%0d", nack, p, exp_id);
                else passed++;
                total++; if (c - last_c != ((last_c < 0) ? c + 1 : 3) || (last_c < 0 && c != 2))
                    $display("FAIL rr_spacing ack%0d: got cycle %0d prev %0d", nack, c, last_c);
                else passed++;
                if (w[p]) ref_mem[ad[p] / 4] = wd[p];
                else      ref_rd[p] = ref_mem[ad[p] / 4];
                total++; if ((p ? bus.RDataB_40 : bus.RDataA_40) !== ref_rd[p])
                    $display("FAIL rr_rdata port%0d: got %h exp %h", p, p ? bus.RDataB_40 : bus.RDataA_40, ref_rd[p]);
                else passed++;
                last_c = c; nack++; cnt[p]++; exp_id = 1 - p;
                if (cnt[p] == 3) drive(p, 0, 0, '0, '0);
                else begin
                    w[p] = 1'($urandom); ad[p] = 32'($urandom_range(63)) * 4; wd[p] = $urandom;
                    drive(p, 1, w[p], ad[p], wd[p]);
                end
            end
        end
        total++; if (nack != 6) $display("FAIL rr_timeout: got %0d acks exp 6", nack);
        else passed++;
        ref_ptr = (exp_id == 1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs[3];
        int k, last_c, idle_cnt;
        addrs = '{32'h00, 32'h04, 32'h08}; k = 0; last_c = 0; idle_cnt = 0;
        @(negedge Clk_40) drive(1, 1, 0, addrs[0], '0);
        for (int c = 0; c < 30 && k < 3; c++) begin
            if (c > 0) @(negedge Clk_40);
            if (k > 0 && !bus.Busy_40) idle_cnt++;
            total++; if (bus.AckA_40 !== 1'b0) $display("FAIL b2b_ackA cycle%0d: got 1 exp 0", c);
            else passed++;
            if (bus.AckB_40) begin
                total++; if (c - last_c != ((k == 0) ? 2 : 3))
                    $display("FAIL b2b_spacing ack%0d: got %0d cycles", k, c - last_c);
                else passed++;
                total++; if (bus.RDataB_40 !== ref_mem[addrs[k] / 4])
                    $display("FAIL b2b_rdata ack%0d: got %h exp %h", k, bus.RDataB_40, ref_mem[addrs[k] / 4]);
                else passed++;
                if (k > 0) begin
                    total++; if (idle_cnt != 1) $display("FAIL b2b_idle ack%0d: got %0d idle cycles exp 1", k, idle_cnt);
                    else passed++;
                end
                ref_rd[1] = ref_mem[addrs[k] / 4];
                idle_cnt = 0; last_c = c; k++;
                if (k < 3) drive(1, 1, 0, addrs[k], '0);
                else       drive(1, 0, 0, '0, '0);
            end
        end
        total++; if (k != 3) $display("FAIL b2b_timeout: got %0d acks exp 3", k);
        else passed++;
        ref_ptr = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            bit va = ($urandom_range(3) != 0), vb = ($urandom_range(3) != 0);
            if (!va && !vb) va = 1;
            do_txn(va, 1'($urandom), rand_addr(), $urandom, vb, 1'($urandom), rand_addr(), $urandom);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = preload(i);
        ref_rd = '{32'h0, 32'h0};
        ref_ptr = 0;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        test_reset();
        test_reset_mid_write();
        test_simultaneous();
        test_single_a();
        test_round_robin();
        test_errors();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port 32-bit data memory between two requesters: port A (CPU MEM stage) and port B (debug/DMA loader).
- Each access is a req/ack transaction. A 3-state FSM grants one requester at a time, drives the memory's Address/WriteData/MemRead/MemWrite for exactly one access cycle, and returns read data with a one-cycle ack.
- Sits between the pipeline/loader and the data memory, replacing their direct connection.

Parameters:
- DATA_W, 32, data width of memory, requester write data and read data.
- ADDR_W, 32, byte-address width.
- DEPTH_WORDS, 64, number of 32-bit words in the data memory; used for range checking.

Ports:
- Clk_40  in  1  clock; all state changes on rising edge.
- Reset_40  in  1  asynchronous, active-high reset.
- ReqA_40  in  1  port A request; held high until AckA_40.
- WrA_40  in  1  port A: 1 = write, 0 = read; valid while ReqA_40.
- AddrA_40  in  ADDR_W  port A byte address.
- WDataA_40  in  DATA_W  port A write data.
- AckA_40  out  1  port A one-cycle completion pulse.
- ErrA_40  out  1  port A error flag; valid with AckA_40.
- RDataA_40  out  DATA_W  port A read data; valid with AckA_40, held until next port A completion.
- ReqB_40, WrB_40, AddrB_40, WDataB_40, AckB_40, ErrB_40, RDataB_40: same as port A, for port B.
- MemAddress_40  out  ADDR_W  to data memory Address.
- MemWriteData_40  out  DATA_W  to data memory WriteData.
- MemRead_40  out  1  to data memory MemRead.
- MemWrite_40  out  1  to data memory MemWrite.
- MemReadData_40  in  DATA_W  from data memory ReadData (combinational read).
- Busy_40  out  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (async, immediate):
  - state = IDLE, priority pointer = A.
  - All Ack/Err = 0, RDataA/B = 0.
  - MemAddress/MemWriteData = 0, MemRead = MemWrite = 0, Busy = 0.
  - Reset mid-ACCESS aborts the access; MemWrite drops asynchronously, so no write commits.
- FSM states:
  - IDLE -> ACCESS: on any Req. Latch the winner's Wr/Addr/WData and its id.
  - IDLE -> DONE: if the winner's address is invalid. Skip the memory access and set Err.
  - ACCESS -> DONE: always, after one cycle.
  - DONE -> IDLE: always, after one cycle.
- Arbitration (IDLE only):
  - Single requester wins.
  - Both requesting: the side named by the priority pointer wins.
  - After each grant the pointer moves to the non-granted side (round-robin); it is updated on grant, not on completion.
- Address check: invalid if Addr[1:0] != 0, or (Addr >> 2) >= DEPTH_WORDS.
- ACCESS cycle:
  - MemAddress and MemWriteData are driven from the latched command.
  - MemWrite = latched Wr; MemRead = !latched Wr.
  - Memory write commits at the rising edge ending ACCESS.
  - For a read, MemReadData is captured into the winner's RData register at that same edge.
- Outside ACCESS: MemRead = MemWrite = 0; MemAddress/MemWriteData hold their last value.
  - All memory controls are decoded from registered state only (no requester-input paths), so they are glitch-free.
- DONE cycle:
  - Winner's Ack = 1 for exactly one cycle, Err = latched error.
  - Loser's Ack = 0; RData is unchanged on writes and on errors.
- Latency: Req seen in cycle 0; ACCESS in cycle 1; Ack in cycle 2; next grant no earlier than cycle 3.
- Requester rules:
  - Inputs must be stable while Req is high.
  - Req drops in the cycle after Ack, or stays high to start a back-to-back transaction.
- Req deasserted before Ack (protocol violation): the transaction still completes and Ack still pulses; no abort.
- Ack timing rules:
  - Never AckA and AckB in the same cycle.
  - Ack never occurs without a prior grant.

Decomposition:
- Shared package dmem_arb_pkg:
  - state encoding typedef: IDLE = 2'b00, ACCESS = 2'b01, DONE = 2'b10.
  - requester-id constants: REQ_A = 1'b0, REQ_B = 1'b1.
  - address-check helper function.
- Sub-module rr_arbiter2: 2-input round-robin grant logic with pointer register; reusable for later shared resources. Everything else is flat.

Test Plan:
- Reset mid-write: assert Reset_40 during ACCESS of an A write of 0xDEADBEEF to 0x10 -> MemWrite_40 = 0 immediately, word 4 unchanged, all outputs at reset values, pointer = A.
- Single write/read on A: write 0x12345678 to addr 0x08 (cycle 0) -> MemWrite_40 = 1 with MemAddress_40 = 0x08 in cycle 1, AckA_40 in cycle 2, ErrA_40 = 0. Then read 0x08 -> RDataA_40 = 0x12345678 with AckA_40.
- Simultaneous requests after reset: A read 0x00 and B write 0xCAFEF00D to 0x04 -> A is served first; B is granted in the IDLE after A's DONE; B's Ack arrives 3 cycles after A's Ack. A then reads 0x04 -> 0xCAFEF00D.
- Round-robin fairness: A and B both hold Req for 6 transactions -> Acks alternate A, B, A, B, A, B; each Ack is 3 cycles apart; never both Acks in one cycle.
- Misaligned and out-of-range accesses: B write to 0x06, then A read of 0x100 (word 64, DEPTH 64) -> each Acks in cycle 1 (IDLE -> DONE) with Err = 1; MemWrite_40 and MemRead_40 never assert; RDataA_40 keeps its prior value.
- Back-to-back on B: ReqB_40 held high for reads of 0x00, 0x04, 0x08 with no A traffic -> AckB_40 every 3 cycles, Busy_40 low for exactly 1 cycle between transactions, read data matches preloaded memory contents.
